// File: rtl/alarm_sequencer.sv
// Arming/alarm sequencer for the motion/door/window intrusion detector.
// Phases are timed by a prescaled tick; the alarm cause is latched in zone.
module alarm_sequencer #(
    parameter int TICK_DIV    = 1000,
    parameter int EXIT_TICKS  = 30,
    parameter int ENTRY_TICKS = 15,
    parameter int ALARM_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       motion,
    input  logic       door,
    input  logic       window,
    input  logic       arm,
    input  logic       disarm,
    output logic       alarm,
    output logic       armed,
    output logic       beep,
    output logic       arm_fault,
    output logic [2:0] state,
    output logic [2:0] zone
);

    localparam int MAXT_A = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
    localparam int MAXT   = (MAXT_A > ALARM_TICKS) ? MAXT_A : ALARM_TICKS;
    localparam int PW     = $clog2(TICK_DIV);
    localparam int TW     = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_pre;
    logic [TW-1:0]   r_ticks;
    logic            r_arm_q;
    logic            r_alarm;
    logic            r_armed;
    logic            r_beep;
    logic            r_fault;
    logic [2:0]      r_zone;
    logic [2:0]      w_zone;
    logic            w_fault;
    logic            w_rise;
    logic            w_tick;

    assign w_rise = arm & ~r_arm_q;
    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_comb begin
        w_next  = r_state;
        w_zone  = r_zone;
        w_fault = 1'b0;
        if (disarm) begin
            w_next = S_DISARMED;
            w_zone = 3'b000;
        end else begin
            case (r_state)
                S_DISARMED: begin
                    if (w_rise) begin
                        if (window) w_fault = 1'b1;
                        else        w_next  = S_EXIT;
                    end
                end
                S_EXIT: begin
                    if (w_tick && r_ticks == TW'(EXIT_TICKS - 1))
                        w_next = S_ARMED;
                end
                S_ARMED: begin
                    if (window || motion) begin
                        w_next = S_ALARM;
                        w_zone = r_zone | {window, door, motion};
                    end else if (door) begin
                        w_next    = S_ENTRY;
                        w_zone[1] = 1'b1;
                    end
                end
                S_ENTRY: begin
                    if (window) begin
                        w_next    = S_ALARM;
                        w_zone[2] = 1'b1;
                    end else if (w_tick && r_ticks == TW'(ENTRY_TICKS - 1)) begin
                        w_next = S_ALARM;
                    end
                end
                S_ALARM: begin
                    // Re-arm unconditionally; live sensors are judged next edge.
                    if (w_tick && r_ticks == TW'(ALARM_TICKS - 1))
                        w_next = S_ARMED;
                end
                default: w_next = S_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_DISARMED;
            r_pre   <= '0;
            r_ticks <= '0;
            r_arm_q <= 1'b0;
            r_alarm <= 1'b0;
            r_armed <= 1'b0;
            r_beep  <= 1'b0;
            r_fault <= 1'b0;
            r_zone  <= 3'b000;
        end else if (ena) begin
            r_state <= w_next;
            r_arm_q <= arm;
            r_zone  <= w_zone;
            r_fault <= w_fault;
            r_alarm <= (w_next == S_ALARM);
            r_armed <= (w_next == S_ARMED) || (w_next == S_ENTRY);
            r_beep  <= (w_next == S_EXIT) || (w_next == S_ENTRY);
            if (w_next != r_state) begin
                r_pre   <= '0;
                r_ticks <= '0;
            end else if (w_tick) begin
                r_pre   <= '0;
                r_ticks <= r_ticks + TW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign state     = r_state;
    assign zone      = r_zone;
    assign alarm     = r_alarm;
    assign armed     = r_armed;
    assign beep      = r_beep;
    assign arm_fault = r_fault & ena;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed scenarios plus randomized traffic for alarm_sequencer,
// checked against a cycle-count reference model.
module tb_alarm_sequencer;

    localparam int TD  = 2;
    localparam int EXT = 3;
    localparam int ENT = 2;
    localparam int ALT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       motion = 1'b0;
    logic       door = 1'b0;
    logic       window = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       alarm;
    logic       armed;
    logic       beep;
    logic       arm_fault;
    logic [2:0] state;
    logic [2:0] zone;

    int checks = 0;
    int errors = 0;

    int         m_st = 0;
    int         m_el = 0;
    logic [2:0] m_zone = 3'b000;
    logic       m_armq = 1'b0;
    logic       m_fault = 1'b0;

    alarm_sequencer #(
        .TICK_DIV(TD), .EXIT_TICKS(EXT),
        .ENTRY_TICKS(ENT), .ALARM_TICKS(ALT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .motion(motion), .door(door), .window(window),
        .arm(arm), .disarm(disarm),
        .alarm(alarm), .armed(armed), .beep(beep),
        .arm_fault(arm_fault), .state(state), .zone(zone)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Timed phase of N ticks ends on the N*TD-th enabled edge after entry.
    task automatic model_edge();
        int  nst;
        logic rise;
        logic flt;
        if (!rst_n) begin
            m_st = 0; m_el = 0; m_zone = 3'b000;
            m_armq = 1'b0; m_fault = 1'b0;
        end else if (ena) begin
            rise = arm && !m_armq;
            m_armq = arm;
            nst = m_st;
            flt = 1'b0;
            if (disarm) begin
                nst = 0;
                m_zone = 3'b000;
            end else if (m_st == 0) begin
                if (rise && window) flt = 1'b1;
                else if (rise) nst = 1;
            end else if (m_st == 1) begin
                if (m_el == EXT * TD - 1) nst = 2;
            end else if (m_st == 2) begin
                if (window || motion) begin
                    nst = 4;
                    m_zone = m_zone | {window, door, motion};
                end else if (door) begin
                    nst = 3;
                    m_zone[1] = 1'b1;
                end
            end else if (m_st == 3) begin
                if (window) begin
                    nst = 4;
                    m_zone[2] = 1'b1;
                end else if (m_el == ENT * TD - 1) begin
                    nst = 4;
                end
            end else if (m_st == 4) begin
                if (m_el == ALT * TD - 1) nst = 2;
            end
            m_el = (nst != m_st) ? 0 : m_el + 1;
            m_st = nst;
            m_fault = flt;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_state", state, m_st);
        chk("m_zone", zone, m_zone);
        chk("m_alarm", alarm, m_st == 4);
        chk("m_armed", armed, m_st == 2 || m_st == 3);
        chk("m_beep", beep, m_st == 1 || m_st == 3);
        chk("m_fault", arm_fault, m_fault && ena);
    endtask

    task automatic arm_to_armed();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        repeat (EXT * TD) cyc();
        chk("armed_reached", state, 3'd2);
    endtask

    initial begin
        // 1: reset, arm, exit delay with motion ignored
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_state", state, 3'd0);
        chk("rst_zone", zone, 3'd0);
        chk("rst_outs", {alarm, armed, beep, arm_fault}, 4'b0000);
        rst_n = 1'b1;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("exit_state", state, 3'd1);
        chk("exit_beep", beep, 1'b1);
        for (int i = 0; i < EXT * TD - 1; i++) begin
            motion = i[0];
            cyc();
            chk("exit_hold", state, 3'd1);
        end
        motion = 1'b0;
        cyc();
        chk("armed_state", state, 3'd2);
        chk("armed_flags", {armed, beep}, 2'b10);

        // 2: window -> alarm, re-arm after ALARM_TICKS
        window = 1'b1;
        cyc();
        window = 1'b0;
        chk("win_alarm", {state, alarm, zone}, {3'd4, 1'b1, 3'b100});
        repeat (ALT * TD - 1) cyc();
        chk("alarm_hold", state, 3'd4);
        cyc();
        chk("rearm", {state, alarm, zone}, {3'd2, 1'b0, 3'b100});

        // 3: door -> entry delay -> alarm, then disarm
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        arm_to_armed();
        door = 1'b1;
        cyc();
        door = 1'b0;
        chk("entry", {state, beep, zone}, {3'd3, 1'b1, 3'b010});
        repeat (ENT * TD - 1) cyc();
        chk("entry_hold", state, 3'd3);
        cyc();
        chk("entry_to", {state, alarm}, {3'd4, 1'b1});
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("disarm", {state, zone, alarm}, {3'd0, 3'b000, 1'b0});

        // 4: entry delay ignores motion, window alarms at once
        arm_to_armed();
        door = 1'b1;
        cyc();
        door = 1'b0;
        motion = 1'b1;
        cyc();
        motion = 1'b0;
        chk("entry_motion", state, 3'd3);
        window = 1'b1;
        cyc();
        window = 1'b0;
        chk("entry_win", {state, zone}, {3'd4, 3'b110});

        // 5: arm rejected with window open; disarm beats arm
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        window = 1'b1;
        arm = 1'b1;
        cyc();
        chk("fault_pulse", {arm_fault, state}, {1'b1, 3'd0});
        cyc();
        chk("fault_clear", {arm_fault, state}, {1'b0, 3'd0});
        arm = 1'b0;
        window = 1'b0;
        cyc();
        arm = 1'b1;
        disarm = 1'b1;
        cyc();
        chk("disarm_wins", state, 3'd0);
        disarm = 1'b0;
        cyc();
        chk("arm_held", state, 3'd0);
        arm = 1'b0;
        cyc();

        // 6: freeze mid exit delay, then reset mid alarm
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        cyc();
        cyc();
        ena = 1'b0;
        repeat (5) begin
            cyc();
            chk("frozen", state, 3'd1);
        end
        ena = 1'b1;
        repeat (EXT * TD - 3) begin
            cyc();
            chk("late_exit", state, 3'd1);
        end
        cyc();
        chk("late_armed", state, 3'd2);
        motion = 1'b1;
        cyc();
        motion = 1'b0;
        chk("motion_alarm", {state, zone}, {3'd4, 3'b001});
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("rst_alarm", {state, zone, alarm, armed, beep}, 9'd0);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            disarm = ($urandom_range(0, 59) == 0);
            window = ($urandom_range(0, 11) == 0);
            door   = ($urandom_range(0, 9) == 0);
            motion = ($urandom_range(0, 11) == 0);
            arm    = ($urandom_range(0, 3) == 0);
            ena    = ($urandom_range(0, 9) != 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
